// File: rtl/conv3x3_lb_param.sv
// rtl/conv3x3_lb_param.sv - streaming 3x3 convolution with two internal line buffers
// Define CONV_CLAMP_EN to saturate results into [0, 2^OW-1] instead of wrapping.
module conv3x3_lb_param #(
  parameter int DW    = 16,
  parameter int CW    = 8,
  parameter int OW    = 20,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          i_en,
  input  logic          coef_we,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          o_en,
  output logic [OW-1:0] result,
  output logic          done,
  output logic          busy
);
  localparam int PW  = DW + CW + 1;
  localparam int AW  = DW + CW + 5;
  localparam int XW  = (AW > OW) ? AW : OW + 1;
  localparam int CLW = $clog2(IMG_W);
  localparam int RLW = $clog2(IMG_H);
  localparam logic [CLW-1:0] COL_LAST = CLW'(IMG_W - 1);
  localparam logic [RLW-1:0] ROW_LAST = RLW'(IMG_H - 1);
`ifdef CONV_CLAMP_EN
  localparam logic signed [XW-1:0] MAX_V = {{(XW - OW){1'b0}}, {OW{1'b1}}};
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CLW-1:0]        col_q, col_d;
  logic [RLW-1:0]        row_q, row_d;
  logic                  drain_q, drain_d;
  logic [DW-1:0]         win_q [9];
  logic [DW-1:0]         win_d [9];
  logic signed [CW-1:0]  coef_q [9];
  logic signed [CW-1:0]  coef_d [9];
  logic signed [PW-1:0]  prod_q [9];
  logic signed [PW-1:0]  prod_d [9];
  logic                  valid1_q, valid1_d;
  logic                  o_en_q, o_en_d;
  logic [OW-1:0]         result_q, result_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [DW-1:0]         lb0_mem [IMG_W];
  logic [DW-1:0]         lb1_mem [IMG_W];
  logic [DW-1:0]         lb0_rd, lb1_rd;
  logic                  accept;
  logic signed [AW-1:0]  acc;
  logic signed [XW-1:0]  scaled;

  assign accept = i_en && (state_q == IDLE || state_q == RUN);
  assign lb0_rd = lb0_mem[col_q];
  assign lb1_rd = lb1_mem[col_q];

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    drain_d  = 1'b0;
    win_d    = win_q;
    coef_d   = coef_q;
    valid1_d = 1'b0;
    o_en_d   = valid1_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    acc      = '0;
    scaled   = '0;

    case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        busy_d  = 1'b1;
      end
      RUN: if (accept && col_q == COL_LAST && row_q == ROW_LAST) state_d = DRAIN;
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (coef_we && state_q == IDLE && coef_addr < 4'd9) coef_d[coef_addr] = coef_data;

    // Newest column enters at wcol 2; wrow 0 is the oldest line.
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = din;
      valid1_d = (row_q >= RLW'(2)) && (col_q >= CLW'(2));
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RLW'(1);
      end else begin
        col_d = col_q + CLW'(1);
      end
    end

    // Products are taken from the next window so the result lands two cycles after the strobe.
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = PW'($signed({1'b0, win_d[k]})) * PW'(coef_q[k]);
    end

    for (int k = 0; k < 9; k++) acc = acc + AW'(prod_q[k]);
    scaled = XW'(acc >>> SHIFT);
    if (valid1_q) begin
`ifdef CONV_CLAMP_EN
      if (scaled[XW-1])        result_d = '0;
      else if (scaled > MAX_V) result_d = '1;
      else                     result_d = scaled[OW-1:0];
`else
      result_d = OW'(scaled);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[col_q] <= din;
      lb1_mem[col_q] <= lb0_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      drain_q  <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k]  <= '0;
        coef_q[k] <= CW'(1);
        prod_q[k] <= '0;
      end
      valid1_q <= 1'b0;
      o_en_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      drain_q  <= drain_d;
      win_q    <= win_d;
      coef_q   <= coef_d;
      prod_q   <= prod_d;
      valid1_q <= valid1_d;
      o_en_q   <= o_en_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign o_en   = o_en_q;
  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_conv3x3_lb_param.sv
// tb/tb_conv3x3_lb_param.sv - self-checking bench for conv3x3_lb_param on a 4x4 frame
module tb_conv3x3_lb_param;
  localparam int DW = 16, CW = 8, OW = 20, W = 4, H = 4, SHIFT = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          i_en;
  logic          coef_we;
  logic [3:0]    coef_addr;
  logic [CW-1:0] coef_data;
  logic          o_en;
  logic [OW-1:0] result;
  logic          done;
  logic          busy;

  conv3x3_lb_param #(.DW(DW), .CW(CW), .OW(OW), .IMG_W(W), .IMG_H(H), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .din(din), .i_en(i_en), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .o_en(o_en), .result(result),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [OW-1:0] res_q[$];
  int            ocyc_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  always @(negedge clk) begin
    if (o_en) begin
      res_q.push_back(result);
      ocyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  typedef struct {
    string name;
    int    mode;
    int    gap;
    int    we_at;
    int    coef[9];
    int    exp[4];
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cur_pix[W*H];
  int cur_coef[9];
  int exp_res[4];
  int strobe_cyc[W*H];
  int res_base, done_base;
  vec_t vecs[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int wrap_or_clamp(input longint s);
`ifdef CONV_CLAMP_EN
    if (s < 0) return 0;
    if (s > 64'hFFFFF) return 'hFFFFF;
    return int'(s);
`else
    return int'(s & 64'hFFFFF);
`endif
  endfunction

  // Plain 2D convolution over every fully-inside window, raster order.
  function automatic void model();
    for (int cr = 1; cr < H - 1; cr++)
      for (int cc = 1; cc < W - 1; cc++) begin
        longint s = 0;
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            s += longint'(cur_coef[3*wr+wc]) * longint'(cur_pix[(cr-1+wr)*W + cc-1+wc]);
        exp_res[(cr-1)*(W-2) + cc-1] = wrap_or_clamp(s >>> SHIFT);
      end
  endfunction

  task automatic load_coefs();
    for (int k = 0; k < 9; k++) begin
      coef_we = 1'b1;
      coef_addr = 4'(k);
      coef_data = 8'(cur_coef[k]);
      @(posedge clk); #1;
      coef_we = 1'b0;
    end
  endtask

  task automatic start_frame();
    done_base = done_cnt;
    res_base = res_q.size();
  endtask

  task automatic drive(input int npix, input int gap, input int we_at);
    int g;
    for (int p = 0; p < npix; p++) begin
      din = DW'(cur_pix[p]);
      i_en = 1'b1;
      strobe_cyc[p] = cyc;
      if (p == we_at) begin
        coef_we = 1'b1;
        coef_addr = 4'd4;
        coef_data = 8'd7;
      end
      @(posedge clk); #1;
      i_en = 1'b0;
      coef_we = 1'b0;
      if (p == 0) chk("busy_after_first_pixel", busy, 1);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int i = 0; i < g; i++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic finish_frame(input string nm);
    int i, n;
    int idx[4];
    idx = '{10, 11, 14, 15};
    i = 0;
    while (done_cnt == done_base && i < 600) begin
      @(negedge clk);
      i++;
    end
    repeat (4) @(negedge clk);
    n = res_q.size() - res_base;
    chk({nm, ".n_results"}, n, 4);
    chk({nm, ".n_done"}, done_cnt - done_base, 1);
    for (int k = 0; k < 4 && k < n; k++) begin
      chk($sformatf("%s.result%0d", nm, k), res_q[res_base+k], exp_res[k]);
      chk($sformatf("%s.latency%0d", nm, k), ocyc_q[res_base+k] - strobe_cyc[idx[k]], 2);
    end
    if (n > 0) chk({nm, ".done_after_last"}, done_cyc - ocyc_q[res_q.size()-1], 1);
    chk({nm, ".busy_low"}, busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; din = '0; i_en = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;

    vecs[0].name = "box_b2b";   vecs[0].mode = 0; vecs[0].gap = 0;  vecs[0].we_at = -1;
    vecs[0].coef = '{1, 1, 1, 1, 1, 1, 1, 1, 1};  vecs[0].exp = '{45, 54, 81, 90};
    vecs[1].name = "box_gap24"; vecs[1].mode = 0; vecs[1].gap = 24; vecs[1].we_at = -1;
    vecs[1].coef = '{1, 1, 1, 1, 1, 1, 1, 1, 1};  vecs[1].exp = '{45, 54, 81, 90};
    vecs[2].name = "center2";   vecs[2].mode = 0; vecs[2].gap = 0;  vecs[2].we_at = 5;
    vecs[2].coef = '{0, 0, 0, 0, 2, 0, 0, 0, 0};  vecs[2].exp = '{10, 12, 18, 20};
    vecs[3].name = "neg_center"; vecs[3].mode = 1; vecs[3].gap = 1; vecs[3].we_at = -1;
    vecs[3].coef = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
    vecs[4].name = "all_max";   vecs[4].mode = 2; vecs[4].gap = 0;  vecs[4].we_at = -1;
    vecs[4].coef = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
`ifdef CONV_CLAMP_EN
    vecs[3].exp = '{0, 0, 0, 0};
    vecs[4].exp = '{'hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF};
`else
    vecs[3].exp = '{'hFFFFB, 'hFFFFB, 'hFFFFB, 'hFFFFB};
    vecs[4].exp = '{'h6FB89, 'h6FB89, 'h6FB89, 'h6FB89};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.o_en", o_en, 0);
    chk("reset.result", result, 0);
    chk("reset.done", done, 0);
    chk("reset.busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      for (int p = 0; p < W*H; p++)
        cur_pix[p] = (vecs[v].mode == 0) ? p : (vecs[v].mode == 1) ? 5 : 'hFFFF;
      cur_coef = vecs[v].coef;
      exp_res = vecs[v].exp;
      load_coefs();
      start_frame();
      drive(W*H, vecs[v].gap, vecs[v].we_at);
      finish_frame(vecs[v].name);
    end

    // Reset right after a window-completing pixel: its result must never appear.
    for (int p = 0; p < W*H; p++) cur_pix[p] = p;
    cur_coef = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
    load_coefs();
    start_frame();
    drive(11, 0, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset.no_o_en", res_q.size() - res_base, 0);
    chk("midreset.no_done", done_cnt - done_base, 0);
    chk("midreset.busy", busy, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) cur_coef[k] = 1;
    for (int a = 9; a < 16; a++) begin
      coef_we = 1'b1;
      coef_addr = 4'(a);
      coef_data = 8'd0;
      @(posedge clk); #1;
      coef_we = 1'b0;
    end
    exp_res = '{45, 54, 81, 90};
    start_frame();
    drive(W*H, 0, -1);
    finish_frame("after_reset");

    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < W*H; p++) cur_pix[p] = int'($urandom_range(0, 65535));
      for (int k = 0; k < 9; k++) cur_coef[k] = int'($urandom_range(0, 255)) - 128;
      model();
      load_coefs();
      start_frame();
      drive(W*H, -1, -1);
      finish_frame($sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
